// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with a return-address stack
// One op per unstalled edge: NEXT, JUMP, BRANCH, CALL, RET; sticky stack error flags.
module pc_sequencer #(
  parameter int                 ADDR_W      = 15,
  parameter int                 STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
  input  logic                               CLK,
  input  logic                               CLR,
  input  logic                               stall,
  input  logic [2:0]                         op,
  input  logic [ADDR_W-1:0]                  in_addr,
  input  logic [ADDR_W-1:0]                  offset,
  input  logic                               err_clr,
  output logic [ADDR_W-1:0]                  out_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               err_ovf,
  output logic                               err_unf
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_NEXT   = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_d;
  logic [DW-1:0]     depth_d;
  logic [IW-1:0]     push_idx;
  logic [IW-1:0]     top_idx;
  logic              ovf_d;
  logic              unf_d;
  logic              push;

  assign addr_inc    = out_addr + ADDR_W'(1);
  assign push_idx    = IW'(depth);
  assign top_idx     = IW'(depth - DW'(1));
  assign stack_full  = (depth == DW'(STACK_DEPTH));
  assign stack_empty = (depth == '0);

  // err_clr is applied first so a flag set by this cycle's op overrides it.
  always_comb begin
    addr_d  = addr_inc;
    depth_d = depth;
    ovf_d   = err_ovf & ~err_clr;
    unf_d   = err_unf & ~err_clr;
    push    = 1'b0;
    case (op)
      OP_NEXT:   addr_d = addr_inc;
      OP_JUMP:   addr_d = in_addr;
      OP_BRANCH: addr_d = out_addr + offset;
      OP_CALL: begin
        addr_d = in_addr;
        if (!stack_full) begin
          push    = 1'b1;
          depth_d = depth + DW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_RET: begin
        if (!stack_empty) begin
          addr_d  = stack_mem[top_idx];
          depth_d = depth - DW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      default: addr_d = addr_inc;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      out_addr <= RESET_ADDR;
      depth    <= '0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
    end else if (!stall) begin
      out_addr <= addr_d;
      depth    <= depth_d;
      err_ovf  <= ovf_d;
      err_unf  <= unf_d;
    end
  end

  // Entry contents are left unreset; depth alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (push && !stall) begin
      stack_mem[push_idx] <= addr_inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
// Driver pushes hand-computed post-edge state; a monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam int ADDR_W = 15;
  localparam int SD     = 8;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              stall = 1'b1;
  logic [2:0]        op = 3'b000;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [ADDR_W-1:0] offset = '0;
  logic              err_clr = 1'b0;
  logic [ADDR_W-1:0] out_addr;
  logic [3:0]        depth;
  logic              stack_full;
  logic              stack_empty;
  logic              err_ovf;
  logic              err_unf;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        dep;
    logic              ovf;
    logic              unf;
    string             name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(SD), .RESET_ADDR('0)) dut (
    .CLK(clk), .CLR(clr), .stall(stall), .op(op), .in_addr(in_addr),
    .offset(offset), .err_clr(err_clr), .out_addr(out_addr), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [ADDR_W-1:0] a, input logic [3:0] d,
                             input logic ov, input logic un);
    check({name, ".addr"},  32'(out_addr),    32'(a));
    check({name, ".depth"}, 32'(depth),       32'(d));
    check({name, ".full"},  32'(stack_full),  32'(d == 4'(SD)));
    check({name, ".empty"}, 32'(stack_empty), 32'(d == 4'd0));
    check({name, ".ovf"},   32'(err_ovf),     32'(ov));
    check({name, ".unf"},   32'(err_unf),     32'(un));
  endtask

  // Monitor: every edge that has an expectation queued gets compared.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_state(e.name, e.addr, e.dep, e.ovf, e.unf);
    end
  end

  task automatic step(input string name, input logic [2:0] o, input logic [ADDR_W-1:0] ia,
                      input logic [ADDR_W-1:0] off, input logic st, input logic ec,
                      input logic [ADDR_W-1:0] ea, input logic [3:0] ed,
                      input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    op = o; in_addr = ia; offset = off; stall = st; err_clr = ec;
    e.addr = ea; e.dep = ed; e.ovf = eo; e.unf = eu; e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_state("reset", 15'h0000, 4'd0, 1'b0, 1'b0);
    clr = 1'b0;

    step("next1", 3'b000, '0, '0, 1'b0, 1'b0, 15'h0001, 4'd0, 1'b0, 1'b0);
    step("next2", 3'b000, '0, '0, 1'b0, 1'b0, 15'h0002, 4'd0, 1'b0, 1'b0);
    step("next3", 3'b000, '0, '0, 1'b0, 1'b0, 15'h0003, 4'd0, 1'b0, 1'b0);

    step("jump_max", 3'b001, 15'h7FFF, '0, 1'b0, 1'b0, 15'h7FFF, 4'd0, 1'b0, 1'b0);
    step("wrap",     3'b000, '0,       '0, 1'b0, 1'b0, 15'h0000, 4'd0, 1'b0, 1'b0);

    step("jump_10",  3'b001, 15'h0010, '0,       1'b0, 1'b0, 15'h0010, 4'd0, 1'b0, 1'b0);
    step("br_neg4",  3'b010, '0,       15'h7FFC, 1'b0, 1'b0, 15'h000C, 4'd0, 1'b0, 1'b0);
    step("br_pos5",  3'b010, '0,       15'h0005, 1'b0, 1'b0, 15'h0011, 4'd0, 1'b0, 1'b0);

    step("jump_100", 3'b001, 15'h0100, '0, 1'b0, 1'b0, 15'h0100, 4'd0, 1'b0, 1'b0);
    step("call_200", 3'b011, 15'h0200, '0, 1'b0, 1'b0, 15'h0200, 4'd1, 1'b0, 1'b0);
    step("call_300", 3'b011, 15'h0300, '0, 1'b0, 1'b0, 15'h0300, 4'd2, 1'b0, 1'b0);
    step("ret_a",    3'b100, '0,       '0, 1'b0, 1'b0, 15'h0201, 4'd1, 1'b0, 1'b0);
    step("ret_b",    3'b100, '0,       '0, 1'b0, 1'b0, 15'h0101, 4'd0, 1'b0, 1'b0);

    // Nine calls from 0x0101: stack holds 0x0102, 0x1001..0x1007; ninth overflows.
    for (int i = 0; i < 9; i++)
      step($sformatf("call_ovf%0d", i), 3'b011, 15'(15'h1000 + i), '0, 1'b0, 1'b0,
           15'(15'h1000 + i), (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 1'b0);
    for (int i = 0; i < 7; i++)
      step($sformatf("ret_pop%0d", i), 3'b100, '0, '0, 1'b0, 1'b0,
           15'(15'h1007 - i), 4'(7 - i), 1'b1, 1'b0);
    step("ret_pop7",  3'b100, '0, '0, 1'b0, 1'b0, 15'h0102, 4'd0, 1'b1, 1'b0);
    step("ret_unf",   3'b100, '0, '0, 1'b0, 1'b0, 15'h0103, 4'd0, 1'b1, 1'b1);
    step("clr_flags", 3'b000, '0, '0, 1'b0, 1'b1, 15'h0104, 4'd0, 1'b0, 1'b0);
    step("set_wins",  3'b100, '0, '0, 1'b0, 1'b1, 15'h0105, 4'd0, 1'b0, 1'b1);
    step("clr_again", 3'b000, '0, '0, 1'b0, 1'b1, 15'h0106, 4'd0, 1'b0, 1'b0);
    step("reserved",  3'b101, 15'h5555, 15'h1111, 1'b0, 1'b0, 15'h0107, 4'd0, 1'b0, 1'b0);
    step("unf_set",   3'b100, '0, '0, 1'b0, 1'b0, 15'h0108, 4'd0, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), 3'b001, 15'h2000, '0, 1'b1, 1'b1,
           15'h0108, 4'd0, 1'b0, 1'b1);

    step("call_a", 3'b011, 15'h0300, '0, 1'b0, 1'b0, 15'h0300, 4'd1, 1'b0, 1'b1);
    step("call_b", 3'b011, 15'h0400, '0, 1'b0, 1'b0, 15'h0400, 4'd2, 1'b0, 1'b1);

    // Asynchronous reset pulse strictly between edges.
    @(posedge clk);
    #2 clr = 1'b1;
    #1 check_state("async_clr", 15'h0000, 4'd0, 1'b0, 1'b0);
    #1 clr = 1'b0;

    step("post_clr_ret", 3'b100, '0, '0, 1'b0, 1'b0, 15'h0001, 4'd0, 1'b0, 1'b1);
    step("post_clr_nx",  3'b000, '0, '0, 1'b0, 1'b1, 15'h0002, 4'd0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 15, giving the address width in bits.
REQ-002 The module SHALL have parameter STACK_DEPTH, default 8, giving the number of return-stack entries (minimum 1).
REQ-003 The module SHALL have parameter RESET_ADDR, default 0, giving the out_addr value loaded on reset.
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port CLR, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port stall, input, 1 bit: when 1, hold all state.
REQ-007 The module SHALL have port op, input, 3 bits: operation select (000 NEXT, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET).
REQ-008 The module SHALL have port in_addr, input, ADDR_W bits: absolute target for JUMP/CALL.
REQ-009 The module SHALL have port offset, input, ADDR_W bits: two's-complement displacement for BRANCH.
REQ-010 The module SHALL have port err_clr, input, 1 bit: synchronous clear of sticky error flags.
REQ-011 The module SHALL have port out_addr, output, ADDR_W bits: current program address (registered).
REQ-012 The module SHALL have port depth, output, clog2(STACK_DEPTH+1) bits: number of valid stack entries.
REQ-013 The module SHALL have port stack_full, output, 1 bit: depth == STACK_DEPTH.
REQ-014 The module SHALL have port stack_empty, output, 1 bit: depth == 0.
REQ-015 The module SHALL have port err_ovf, output, 1 bit: sticky flag set by CALL while full.
REQ-016 The module SHALL have port err_unf, output, 1 bit: sticky flag set by RET while empty.

Function
REQ-017 All arithmetic on out_addr SHALL be modulo 2^ADDR_W; out_addr = all-ones followed by NEXT SHALL yield 0.
REQ-018 NEXT SHALL load out_addr+1 on the next edge.
REQ-019 JUMP SHALL load in_addr.
REQ-020 BRANCH SHALL load out_addr+offset, with offset sign-interpreted and truncated to ADDR_W.
REQ-021 CALL with stack not full SHALL push out_addr+1 (mod 2^ADDR_W) at index depth, increment depth, and load in_addr, all on one edge.
REQ-022 CALL with stack full SHALL still load in_addr, leave the stack and depth unchanged, and set err_ovf.
REQ-023 RET with stack not empty SHALL load the top entry and decrement depth on one edge.
REQ-024 RET with stack empty SHALL behave as NEXT and set err_unf.
REQ-025 Reserved op codes 101-111 SHALL behave as NEXT with no flag change.
REQ-026 stall=1 SHALL take priority over op: out_addr, stack, depth and flags SHALL hold, and err_clr SHALL be ignored that cycle.
REQ-027 err_clr=1 with stall=0 SHALL clear both flags; if the same cycle's op sets a flag, the set SHALL win.
REQ-028 stack_full, stack_empty and depth SHALL be combinational decodes of the registered depth with no extra latency.
REQ-029 Every operation SHALL take effect with exactly one cycle latency; out_addr SHALL be visible on the cycle after the op is presented.

Reset
REQ-030 CLR=1 SHALL immediately, independent of CLK, force out_addr=RESET_ADDR, depth=0, err_ovf=0 and err_unf=0.
REQ-031 Stack entry contents need not be reset, and SHALL be unobservable while depth=0.
REQ-032 A CLR asserted mid-sequence (for example, between a CALL and its RET) SHALL discard all pending return addresses.
REQ-033 On the first rising edge after CLR deasserts, normal operation SHALL resume from RESET_ADDR.

Verification
REQ-034 Bench shall cover reset then 3 NEXT cycles -> out_addr 0,1,2,3, depth=0, stack_empty=1.
REQ-035 Bench shall cover wrap-around: JUMP 0x7FFF then NEXT (ADDR_W=15) -> out_addr 0x7FFF, then 0x0000.
REQ-036 Bench shall cover BRANCH: at 0x0010 with offset 0x7FFC (-4) -> 0x000C; then offset 0x0005 -> 0x0011.
REQ-037 Bench shall cover nested calls: at 0x0100 CALL 0x0200, then CALL 0x0300, then RET, RET -> 0x0200, 0x0300, 0x0201, 0x0101, with depth 1,2,1,0.
REQ-038 Bench shall cover overflow and underflow: 9 CALLs at STACK_DEPTH=8 -> depth stays 8, err_ovf=1, 9th target loaded; then 9 RETs -> 9th RET acts as NEXT and sets err_unf=1; then err_clr -> both flags 0.
REQ-039 Bench shall cover stall and asynchronous reset: stall=1 with op=JUMP for 3 cycles -> out_addr unchanged; CLR pulsed between clock edges with depth=2 -> out_addr=RESET_ADDR and depth=0 before the next edge.
